stopwatch_mux_n: RTL and testbench
==================================

// Module: stopwatch_mux_n
// PURPOSE
// Parametrised N-digit BCD stopwatch with an integrated seven-segment display multiplexer.
// - Counts BCD up or down on an internal prescaled tick, with wrap-around and a lap (display-freeze) mode.
// - Scans the digits onto one shared seven-segment bus through active-low anode selects.
// - Board-level top under the board wrapper; generalises the fixed 4-digit, up-only stopwatch path.
// PARAMETERS
// N_DIGITS     4           number of BCD digits, 2..8; digit 0 is least significant
// TICK_DIV     10_000_000  clk cycles per count step (0.1 s at 100 MHz), >= 2
// REFRESH_DIV  100_000     clk cycles each digit is held on the display, >= 2
// DP_DIGIT     1           index of the digit whose decimal point is lit; N_DIGITS = none
// PORTS
// clk     in   1           single system clock
// reset   in   1           synchronous reset, active-high
// enable  in   1           1 = count on tick; 0 = hold count and prescaler
// up      in   1           1 = count up, 0 = count down; sampled at each tick
// lap     in   1           level; each rising edge toggles lap (display freeze) mode
// an      out  N_DIGITS    anode selects, active-low, exactly one low after reset
// sseg    out  8           {dp,g,f,e,d,c,b,a}, active-low
// count   out  4*N_DIGITS  live BCD count, digit i at [4i+3:4i]
// wrap    out  1           one-cycle pulse on full-scale wrap
// RESET (synchronous, active-high, in effect on the cycle it is sampled)
// - count=0, prescaler=0, lap mode off, lap edge register=0, wrap=0.
// - Scan index=0, an=~1 (digit 0 selected), sseg=8'hC0 ("0", dp off).
// - Reset overrides every other input, including mid-tick and lap mode.
// BEHAVIOUR
// Prescaler
// - Runs 0..TICK_DIV-1 only while enable=1; tick = (prescaler==TICK_DIV-1) && enable.
// - enable=0 freezes the prescaler value; it does not clear it.
// Count update (registered; count changes on the clock edge at which tick=1)
// - up=1: digit 0 increments; a digit at 9 rolls to 0 and carries into the next digit.
// - up=0: digit 0 decrements; a digit at 0 rolls to 9 and borrows from the next digit.
// - All 9s going up -> all 0s. All 0s going down -> all 9s.
// - wrap=1 for exactly the cycle after the tick that caused a full-scale rollover.
// - A direction change takes effect on the next tick; there is no glitch or skipped step.
// Lap mode
// - Rising edge of lap (registered edge detect) toggles the lap flag.
// - Entering lap mode copies count into the lap snapshot on the same edge.
// - Lap mode on: the display shows the snapshot while count keeps running.
// - Lap mode off: the display shows the live count.
// - A lap edge on the same cycle as a tick captures the pre-tick count.
// Display scan
// - Refresh counter 0..REFRESH_DIV-1; at terminal count the scan index advances i -> (i+1) mod N_DIGITS.
// - an and sseg are registered and change on the same edge (1 cycle after the index changes), so they never disagree.
// - Segment encoding (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
// - Digit values 10..15 are unreachable; they encode as all segments off (FF).
// - dp bit = 0 only while the scan index == DP_DIGIT.
// STRUCTURE
// - Package sw_pkg: segment encoding constants, a bcd_to_sseg function, DIGIT_W=4.
// - Sub-module sw_bcd_digit, instantiated N_DIGITS times in a generate chain.
//   - Ports: clk, reset, step, up -> digit[3:0], cout (carry/borrow).
//   - step for digit i = tick AND the cout of every lower digit.
// - The scan mux and the prescaler stay inline in this module.
// TESTING (bench parameters: N_DIGITS=4, TICK_DIV=4, REFRESH_DIV=8, DP_DIGIT=1)
// 1. reset 2 cycles, enable=1, up=1, run 40 cycles
//    -> count=16'h0010 after the 10th tick; wrap never pulses.
// 2. force count to 16'h9999 via ticks, up=1, one more tick
//    -> count=16'h0000 and wrap=1 for exactly one cycle.
// 3. from 16'h0000, up=0, one tick
//    -> count=16'h9999 and wrap=1; next tick -> 16'h9998.
// 4. count 16'h0012, lap edge, 8 further ticks
//    -> displayed digits stay 0,0,1,2 while count=16'h0020.
//    -> second lap edge: display shows live 0020 on its next scan.
// 5. idle scan for 40 cycles
//    -> an sequence 1110,1101,1011,0111, each held 8 cycles.
//    -> sseg=8'h40 ("0" with dp) only while an=1101.
// 6. assert reset mid-count (count=16'h0357, lap mode on)
//    -> next cycle count=0, lap off, an=1110, sseg=8'hC0.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the BCD stopwatch: digit width, seven-segment
// codes (active-low, {dp,g,f,e,d,c,b,a}) and the BCD-to-segment decoder.
package sw_pkg;

    localparam int DIGIT_W = 4;

    // Active-low segment patterns with the decimal point off (bit 7 = 1).
    localparam logic [7:0] SSEG_0     = 8'hC0;
    localparam logic [7:0] SSEG_1     = 8'hF9;
    localparam logic [7:0] SSEG_2     = 8'hA4;
    localparam logic [7:0] SSEG_3     = 8'hB0;
    localparam logic [7:0] SSEG_4     = 8'h99;
    localparam logic [7:0] SSEG_5     = 8'h92;
    localparam logic [7:0] SSEG_6     = 8'h82;
    localparam logic [7:0] SSEG_7     = 8'hF8;
    localparam logic [7:0] SSEG_8     = 8'h80;
    localparam logic [7:0] SSEG_9     = 8'h90;
    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    // Which value the display shows: the running count or the frozen lap copy.
    typedef enum logic {
        DISP_LIVE = 1'b0,
        DISP_LAP  = 1'b1
    } disp_src_e;

    // Non-BCD codes (10..15) cannot occur in the counter; they blank the digit.
    function automatic logic [7:0] bcd_to_sseg(input logic [DIGIT_W-1:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SSEG_0;
            4'd1:    s = SSEG_1;
            4'd2:    s = SSEG_2;
            4'd3:    s = SSEG_3;
            4'd4:    s = SSEG_4;
            4'd5:    s = SSEG_5;
            4'd6:    s = SSEG_6;
            4'd7:    s = SSEG_7;
            4'd8:    s = SSEG_8;
            4'd9:    s = SSEG_9;
            default: s = SSEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sw_bcd_digit.sv
// One BCD digit of the stopwatch counter. Steps up or down when step=1;
// cout flags that this digit is about to roll over in the current direction,
// so the next digit up the chain may step on the same tick.
module sw_bcd_digit
    import sw_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               up,
    output logic [DIGIT_W-1:0] digit,
    output logic               cout
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    // Next digit value: 9 -> 0 going up, 0 -> 9 going down.
    always_comb begin
        digit_d = digit_q;
        if (step) begin
            if (up) begin
                digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            end
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign cout  = up ? (digit_q == 4'd9) : (digit_q == 4'd0);
    assign digit = digit_q;

endmodule

// File: rtl/stopwatch_mux_n.sv
// N-digit BCD up/down stopwatch with lap freeze and a multiplexed
// seven-segment display (active-low anodes and segments).
module stopwatch_mux_n
    import sw_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int TICK_DIV    = 10_000_000,
    parameter int REFRESH_DIV = 100_000,
    parameter int DP_DIGIT    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      up,
    input  logic                      lap,
    output logic [N_DIGITS-1:0]       an,
    output logic [7:0]                sseg,
    output logic [DIGIT_W*N_DIGITS-1:0] count,
    output logic                      wrap
);

    localparam int CW = DIGIT_W * N_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);

    localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX     = IW'(N_DIGITS - 1);

    // ---------------------------------------------------------------
    // Prescaler: one count step every TICK_DIV enabled cycles
    // ---------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    assign tick = enable && (presc_q == PRESC_MAX);

    // Advance only while enabled; disabling freezes the phase rather than clearing it.
    always_comb begin
        presc_d = presc_q;
        if (enable) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ---------------------------------------------------------------
    // BCD digit chain
    // ---------------------------------------------------------------
    logic [N_DIGITS-1:0] step_w;
    logic [N_DIGITS-1:0] cout_w;
    logic [CW-1:0]       count_w;
    logic                chain_c;
    logic                full_wrap;

    // Ripple the tick through every digit that is at its rollover value;
    // surviving past the top digit means the whole counter wrapped.
    always_comb begin
        chain_c = tick;
        for (int i = 0; i < N_DIGITS; i++) begin
            step_w[i] = chain_c;
            chain_c   = chain_c & cout_w[i];
        end
        full_wrap = chain_c;
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        sw_bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .step  (step_w[g]),
            .up    (up),
            .digit (count_w[DIGIT_W*g +: DIGIT_W]),
            .cout  (cout_w[g])
        );
    end

    logic wrap_q;

    // Wrap pulse lands in the cycle following the wrapping tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= full_wrap;
        end
    end

    // ---------------------------------------------------------------
    // Lap freeze
    // ---------------------------------------------------------------
    logic          lap_q;
    disp_src_e     lap_mode_q;
    logic [CW-1:0] snap_q;
    logic          lap_rise;
    logic [CW-1:0] disp_val;

    assign lap_rise = lap && !lap_q;

    // Each lap rising edge toggles the mode; entering lap mode grabs the
    // registered count, which is still the pre-tick value on a tick edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_q      <= 1'b0;
            lap_mode_q <= DISP_LIVE;
            snap_q     <= '0;
        end else begin
            lap_q <= lap;
            if (lap_rise) begin
                if (lap_mode_q == DISP_LIVE) begin
                    lap_mode_q <= DISP_LAP;
                    snap_q     <= count_w;
                end else begin
                    lap_mode_q <= DISP_LIVE;
                end
            end
        end
    end

    assign disp_val = (lap_mode_q == DISP_LAP) ? snap_q : count_w;

    // ---------------------------------------------------------------
    // Display scan
    // ---------------------------------------------------------------
    logic [RW-1:0]       refresh_q;
    logic [IW-1:0]       idx_q;
    logic [DIGIT_W-1:0]  cur_digit;
    logic                dp_on;
    logic [7:0]          seg_code;
    logic [N_DIGITS-1:0] an_q;
    logic [N_DIGITS-1:0] an_d;
    logic [7:0]          sseg_q;
    logic [7:0]          sseg_d;

    // Hold each digit REFRESH_DIV cycles, then move to the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else if (refresh_q == REFRESH_MAX) begin
            refresh_q <= '0;
            idx_q     <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    // Pick the selected digit and its decimal point; DP_DIGIT == N_DIGITS never matches.
    always_comb begin
        cur_digit = '0;
        dp_on     = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                cur_digit = disp_val[DIGIT_W*i +: DIGIT_W];
                dp_on     = (i == DP_DIGIT);
            end
        end
        seg_code = bcd_to_sseg(cur_digit);
        an_d     = ~(N_DIGITS'(1) << idx_q);
        sseg_d   = {~dp_on, seg_code[6:0]};
    end

    // Anodes and segments share one register stage so they always agree.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q   <= ~N_DIGITS'(1);
            sseg_q <= SSEG_0;
        end else begin
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign an    = an_q;
    assign sseg  = sseg_q;
    assign count = count_w;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_stopwatch_mux_n.sv
// Self-checking bench for stopwatch_mux_n (N_DIGITS=4, TICK_DIV=4,
// REFRESH_DIV=8, DP_DIGIT=1).
module tb_stopwatch_mux_n;

    localparam int N_DIGITS    = 4;
    localparam int TICK_DIV    = 4;
    localparam int REFRESH_DIV = 8;
    localparam int DP_DIGIT    = 1;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic        up     = 1'b1;
    logic        lap    = 1'b0;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [15:0] count;
    logic        wrap;

    int checks    = 0;
    int errors    = 0;
    int wrap_seen = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic        up;
        int          ticks;
        logic [15:0] exp_count;
        int          exp_wraps;
        logic        exp_wrap_now;
    } vec_t;

    vec_t vecs[10];

    // clock / reset
    always #5 clk = ~clk;

    stopwatch_mux_n #(
        .N_DIGITS    (N_DIGITS),
        .TICK_DIV    (TICK_DIV),
        .REFRESH_DIV (REFRESH_DIV),
        .DP_DIGIT    (DP_DIGIT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .up     (up),
        .lap    (lap),
        .an     (an),
        .sseg   (sseg),
        .count  (count),
        .wrap   (wrap)
    );

    // driver: advance n clocks, sampling 1 ns after each rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (wrap === 1'b1) wrap_seen++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] d, input bit dp_on);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return {~dp_on, s};
    endfunction

    // Watch n cycles of scanning; the first time each digit is selected,
    // its segments must show the matching digit of exp_val.
    task automatic check_display(input logic [15:0] exp_val, input int n, input string name);
        bit         seen[4];
        logic [3:0] sel;
        for (int j = 0; j < 4; j++) seen[j] = 1'b0;
        for (int c = 0; c < n; c++) begin
            step(1);
            for (int j = 0; j < 4; j++) begin
                sel = 4'b0001 << j;
                if (an == ~sel && !seen[j]) begin
                    check($sformatf("%s_d%0d", name, j), {24'h0, sseg},
                          {24'h0, enc(exp_val[4*j +: 4], j == DP_DIGIT)});
                    seen[j] = 1'b1;
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("%s_seen%0d", name, j), {31'h0, seen[j]}, 32'h1);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_count"}, {16'h0, count}, 32'h0);
        check({name, "_an"}, {28'h0, an}, 32'hE);
        check({name, "_sseg"}, {24'h0, sseg}, 32'hC0);
        check({name, "_wrap"}, {31'h0, wrap}, 32'h0);
    endtask

    logic [15:0] got;
    logic [3:0]  an_e;
    logic [7:0]  sseg_e;

    initial begin
        vecs[0] = '{1'b1, 10, 16'h0010, 0, 1'b0};
        vecs[1] = '{1'b1,  2, 16'h0012, 0, 1'b0};
        vecs[2] = '{1'b0,  3, 16'h0009, 0, 1'b0};
        vecs[3] = '{1'b0, 10, 16'h9999, 1, 1'b1};
        vecs[4] = '{1'b0,  1, 16'h9998, 0, 1'b0};
        vecs[5] = '{1'b1,  1, 16'h9999, 0, 1'b0};
        vecs[6] = '{1'b1,  1, 16'h0000, 1, 1'b1};
        vecs[7] = '{1'b0,  1, 16'h9999, 1, 1'b1};
        vecs[8] = '{1'b0,  1, 16'h9998, 0, 1'b0};
        vecs[9] = '{1'b1,  3, 16'h0001, 1, 1'b0};

        // Reset for two cycles with enable already high.
        enable = 1'b1;
        up     = 1'b1;
        reset  = 1'b1;
        step(2);
        check_reset_state("reset");
        reset = 1'b0;

        // Table-driven counting runs; each run is a whole number of ticks.
        for (int v = 0; v < 10; v++) begin
            up = vecs[v].up;
            exp_q.push_back(vecs[v].exp_count);
            wrap_seen = 0;
            step(vecs[v].ticks * TICK_DIV);
            got = exp_q.pop_front();
            check($sformatf("vec%0d_count", v), {16'h0, count}, {16'h0, got});
            check($sformatf("vec%0d_wraps", v), wrap_seen, vecs[v].exp_wraps);
            check($sformatf("vec%0d_wrap_now", v), {31'h0, wrap}, {31'h0, vecs[v].exp_wrap_now});
        end

        // enable=0 freezes the prescaler phase without clearing it.
        up = 1'b1;
        step(2);
        enable = 1'b0;
        step(5);
        check("hold_count", {16'h0, count}, 32'h0001);
        enable = 1'b1;
        step(1);
        check("hold_no_early_tick", {16'h0, count}, 32'h0001);
        step(1);
        check("hold_resume_tick", {16'h0, count}, 32'h0002);

        // Lap freeze: snapshot 0012 while the count runs on to 0020.
        reset = 1'b1;
        step(1);
        reset  = 1'b0;
        enable = 1'b1;
        up     = 1'b1;
        step(12 * TICK_DIV);
        check("lap_pre_count", {16'h0, count}, 32'h0012);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check_display(16'h0012, 31, "lap_frozen");
        enable = 1'b0;
        check("lap_live_count", {16'h0, count}, 32'h0020);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check_display(16'h0020, 40, "lap_off_live");

        // Lap edge coinciding with a tick snapshots the pre-tick count.
        reset = 1'b1;
        step(1);
        reset  = 1'b0;
        enable = 1'b1;
        step(5 * TICK_DIV + 3);
        lap = 1'b1;
        step(1);
        lap    = 1'b0;
        enable = 1'b0;
        check("lap_tick_count", {16'h0, count}, 32'h0006);
        check_display(16'h0005, 40, "lap_pre_tick");

        // Idle scan order and dp placement; reset also drops lap mode.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("scan_an_k0", {28'h0, an}, 32'hE);
        for (int k = 1; k <= 40; k++) begin
            an_e   = ~(4'b0001 << (((k - 1) / REFRESH_DIV) % N_DIGITS));
            sseg_e = (an_e == 4'b1101) ? 8'h40 : 8'hC0;
            exp_q.push_back({4'h0, an_e, sseg_e});
            step(1);
            got = exp_q.pop_front();
            check($sformatf("scan_an_k%0d", k), {28'h0, an}, {28'h0, got[11:8]});
            check($sformatf("scan_sseg_k%0d", k), {24'h0, sseg}, {24'h0, got[7:0]});
        end

        // Reset mid-count with lap mode on.
        enable = 1'b1;
        up     = 1'b1;
        step(357 * TICK_DIV);
        check("mid_count", {16'h0, count}, 32'h0357);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
        check_reset_state("mid_reset");
        reset  = 1'b0;
        enable = 1'b0;
        check_display(16'h0000, 40, "post_reset_live");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
